int_op_unit: RTL and testbench

Integer execution slice for the switch/button calculator front end. It contains three parts:
- a push-button debouncer that produces a clean level and a one-cycle press pulse;
- a 16-bit unsigned arithmetic unit;
- a 16-bit bit-manipulation/shift unit.

The controlling FSM supplies operands and opcode and reads the registered result for LED/UART display.

---
 rtl/int_op_pkg.sv | 23 ++
 rtl/int_op_unit_pb_debounce.sv | 41 ++++
 rtl/int_op_unit.sv | 95 +++++++++
 tb/tb_int_op_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/int_op_pkg.sv
// Shared constants for the integer execution slice: data width, opcodes and unit select.
package int_op_pkg;
  localparam int DATA_W = 16;

  localparam logic UNIT_ARITH = 1'b0;
  localparam logic UNIT_BIT   = 1'b1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_REM = 3'b100;
  localparam logic [2:0] OP_INC = 3'b101;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_SET  = 3'b001;
  localparam logic [2:0] OP_GET  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_ROR  = 3'b111;
endpackage

// File: rtl/int_op_unit_pb_debounce.sv
// Push-button debouncer: 2-flop synchroniser, agreement counter and a one-cycle press pulse.
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_in,
  output logic pb_out,
  output logic pb_rise
);
  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // The edge that would take cnt to DEBOUNCE_CYCLES commits the new level instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      pb_out  <= 1'b0;
      pb_rise <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= pb_in;
      sync2   <= sync1;
      pb_rise <= 1'b0;
      if (sync2 == pb_out) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        pb_out  <= sync2;
        pb_rise <= sync2;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/int_op_unit.sv
// Integer execution slice: debounced button plus registered arithmetic / bit-manipulation result.
module int_op_unit
  import int_op_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int WIDTH           = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pb_in,
  output logic             pb_out,
  output logic             pb_rise,
  input  logic             unit_sel,
  input  logic [2:0]       operation,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] out,
  output logic             div_zero
);
  logic [WIDTH-1:0]   arith_res;
  logic               arith_dz;
  logic [WIDTH-1:0]   bit_res;
  logic [WIDTH-1:0]   mask;
  logic [2*WIDTH-1:0] rol_w;
  logic [2*WIDTH-1:0] ror_w;
  logic [3:0]         k;

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pb (
    .clk     (clk),
    .rst     (rst),
    .pb_in   (pb_in),
    .pb_out  (pb_out),
    .pb_rise (pb_rise)
  );

  always_comb begin
    arith_res = '0;
    arith_dz  = 1'b0;
    case (operation)
      OP_ADD: arith_res = opa + opb;
      OP_SUB: arith_res = opa - opb;
      OP_MUL: arith_res = opa * opb;
      OP_DIV: begin
        if (opb == '0) begin
          arith_res = '1;
          arith_dz  = 1'b1;
        end else begin
          arith_res = opa / opb;
        end
      end
      OP_REM: begin
        if (opb == '0) begin
          arith_res = opa;
          arith_dz  = 1'b1;
        end else begin
          arith_res = opa % opb;
        end
      end
      OP_INC:  arith_res = opa + WIDTH'(1);
      default: arith_res = '0;
    endcase
  end

  // Rotates come from the doubled operand so k=0 needs no special case.
  always_comb begin
    k       = opb[3:0];
    mask    = WIDTH'(1) << k;
    rol_w   = {opa, opa} << k;
    ror_w   = {opa, opa} >> k;
    bit_res = '0;
    case (operation)
      OP_CLR:  bit_res = opa & ~mask;
      OP_SET:  bit_res = opa | mask;
      OP_GET:  bit_res = WIDTH'(opa[k]);
      OP_PASS: bit_res = opa;
      OP_SHL:  bit_res = opa << k;
      OP_SHR:  bit_res = opa >> k;
      OP_ROL:  bit_res = rol_w[2*WIDTH-1:WIDTH];
      default: bit_res = ror_w[WIDTH-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out      <= '0;
      div_zero <= 1'b0;
    end else if (unit_sel == UNIT_BIT) begin
      out      <= bit_res;
      div_zero <= 1'b0;
    end else begin
      out      <= arith_res;
      div_zero <= arith_dz;
    end
  end
endmodule

// File: tb/tb_int_op_unit.sv
// Directed self-checking bench for int_op_unit with a short debounce window.
module tb_int_op_unit;
  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pb_in;
  logic        pb_out;
  logic        pb_rise;
  logic        unit_sel;
  logic [2:0]  operation;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [15:0] out;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sel;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    logic        dz;
  } vec_t;

  int_op_unit #(.DEBOUNCE_CYCLES(DB), .WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_in     (pb_in),
    .pb_out    (pb_out),
    .pb_rise   (pb_rise),
    .unit_sel  (unit_sel),
    .operation (operation),
    .opa       (opa),
    .opb       (opb),
    .out       (out),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    unit_sel  = s;
    operation = o;
    opa       = a;
    opb       = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pb_in = 1'b0;
    drive(1'b0, 3'b011, 16'h0005, 16'h0000);
    step();
    step();
    checks++;
    if (out !== 16'h0000) begin errors++; $display("FAIL reset_out got=%h exp=0000", out); end
    checks++;
    if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    checks++;
    if (pb_out !== 1'b0 || pb_rise !== 1'b0) begin
      errors++; $display("FAIL reset_pb got=%b%b exp=00", pb_out, pb_rise);
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors(input string name, input vec_t v[]);
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].sel, v[i].op, v[i].a, v[i].b);
      step();
      checks++;
      if (out !== v[i].exp) begin
        errors++; $display("FAIL %s[%0d]_out got=%h exp=%h", name, i, out, v[i].exp);
      end
      checks++;
      if (div_zero !== v[i].dz) begin
        errors++; $display("FAIL %s[%0d]_dz got=%b exp=%b", name, i, div_zero, v[i].dz);
      end
    end
  endtask

  task automatic test_arith();
    vec_t v[] = new[6];
    v[0] = '{1'b0, 3'b000, 16'h00FF, 16'h0001, 16'h0100, 1'b0};
    v[1] = '{1'b0, 3'b001, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
    v[2] = '{1'b0, 3'b010, 16'h0100, 16'h0100, 16'h0000, 1'b0};
    v[3] = '{1'b0, 3'b101, 16'hFFFF, 16'h1234, 16'h0000, 1'b0};
    v[4] = '{1'b0, 3'b110, 16'h0005, 16'h0006, 16'h0000, 1'b0};
    v[5] = '{1'b0, 3'b111, 16'h0005, 16'h0006, 16'h0000, 1'b0};
    test_vectors("arith", v);
  endtask

  task automatic test_divide();
    vec_t v[] = new[6];
    v[0] = '{1'b0, 3'b011, 16'd100, 16'd7, 16'd14, 1'b0};
    v[1] = '{1'b0, 3'b100, 16'd100, 16'd7, 16'd2, 1'b0};
    v[2] = '{1'b0, 3'b011, 16'd100, 16'd0, 16'hFFFF, 1'b1};
    v[3] = '{1'b0, 3'b100, 16'd9, 16'd0, 16'd9, 1'b1};
    v[4] = '{1'b1, 3'b011, 16'h0000, 16'h0000, 16'h0000, 1'b0};
    v[5] = '{1'b0, 3'b011, 16'hFFFF, 16'h0010, 16'h0FFF, 1'b0};
    test_vectors("divide", v);
  endtask

  task automatic test_bits();
    vec_t v[] = new[5];
    v[0] = '{1'b1, 3'b000, 16'h00F0, 16'd4, 16'h00E0, 1'b0};
    v[1] = '{1'b1, 3'b001, 16'h00F0, 16'd15, 16'h80F0, 1'b0};
    v[2] = '{1'b1, 3'b010, 16'h00F0, 16'd5, 16'h0001, 1'b0};
    v[3] = '{1'b1, 3'b010, 16'h00F0, 16'h0013, 16'h0000, 1'b0};
    v[4] = '{1'b1, 3'b011, 16'h00F0, 16'hFFFF, 16'h00F0, 1'b0};
    test_vectors("bits", v);
  endtask

  task automatic test_shifts();
    vec_t v[] = new[8];
    v[0] = '{1'b1, 3'b100, 16'h8001, 16'd1, 16'h0002, 1'b0};
    v[1] = '{1'b1, 3'b101, 16'h8001, 16'd15, 16'h0001, 1'b0};
    v[2] = '{1'b1, 3'b110, 16'h8001, 16'd1, 16'h0003, 1'b0};
    v[3] = '{1'b1, 3'b111, 16'h8001, 16'd1, 16'hC000, 1'b0};
    v[4] = '{1'b1, 3'b100, 16'h8001, 16'd0, 16'h8001, 1'b0};
    v[5] = '{1'b1, 3'b110, 16'h8001, 16'h0010, 16'h8001, 1'b0};
    v[6] = '{1'b1, 3'b111, 16'h8001, 16'd15, 16'h0003, 1'b0};
    v[7] = '{1'b1, 3'b100, 16'h8001, 16'd15, 16'h8000, 1'b0};
    test_vectors("shift", v);
  endtask

  task automatic test_debounce();
    logic seen;
    // glitch of DB-1 cycles must vanish
    seen = 1'b0;
    pb_in = 1'b1;
    for (int i = 0; i < DB - 1; i++) begin
      step();
      if (pb_out !== 1'b0 || pb_rise !== 1'b0) seen = 1'b1;
    end
    pb_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (pb_out !== 1'b0 || pb_rise !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL glitch_pb got=1 exp=0"); end

    pb_in = 1'b1;
    for (int e = 1; e <= DB + 3; e++) begin
      step();
      checks++;
      if (pb_out !== (e >= DB + 2)) begin
        errors++; $display("FAIL press_out edge=%0d got=%b exp=%b", e, pb_out, (e >= DB + 2));
      end
      checks++;
      if (pb_rise !== (e == DB + 2)) begin
        errors++; $display("FAIL press_rise edge=%0d got=%b exp=%b", e, pb_rise, (e == DB + 2));
      end
    end

    pb_in = 1'b0;
    for (int e = 1; e <= DB + 3; e++) begin
      step();
      checks++;
      if (pb_out !== (e < DB + 2)) begin
        errors++; $display("FAIL release_out edge=%0d got=%b exp=%b", e, pb_out, (e < DB + 2));
      end
      checks++;
      if (pb_rise !== 1'b0) begin
        errors++; $display("FAIL release_rise edge=%0d got=%b exp=0", e, pb_rise);
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 3'b000, 16'h1234, 16'h0000);
    pb_in = 1'b1;
    for (int i = 0; i < DB + 2; i++) step();
    checks++;
    if (out !== 16'h1234 || pb_out !== 1'b1) begin
      errors++; $display("FAIL pre_reset got=%h/%b exp=1234/1", out, pb_out);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (out !== 16'h0000 || div_zero !== 1'b0) begin
      errors++; $display("FAIL midrst_out got=%h/%b exp=0000/0", out, div_zero);
    end
    checks++;
    if (pb_out !== 1'b0 || pb_rise !== 1'b0) begin
      errors++; $display("FAIL midrst_pb got=%b%b exp=00", pb_out, pb_rise);
    end
    for (int e = 1; e <= DB + 2; e++) begin
      step();
      checks++;
      if (pb_out !== (e == DB + 2)) begin
        errors++; $display("FAIL rerise edge=%0d got=%b exp=%b", e, pb_out, (e == DB + 2));
      end
      if (e == 1) begin
        checks++;
        if (out !== 16'h1234) begin errors++; $display("FAIL post_rst_out got=%h exp=1234", out); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_divide();
    test_bits();
    test_shifts();
    test_debounce();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
